rom_loader_bridge: RTL
======================

ROM_LOADER_BRIDGE -- requirements
Module: rom_loader_bridge

Interface
REQ-001 Parameter BASE_ADDR, default 26'h0400000, SDRAM byte base address for the loaded image.
REQ-002 Parameter ACK_TIMEOUT, default 255, maximum cycles to wait for wb_ack before aborting a cycle.
REQ-003 clk_sys  in  1  system clock; single clock domain.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 dl_en  in  1  download of this image active; rising edge starts, falling edge ends.
REQ-006 dl_wr  in  1  one-cycle strobe, dl_addr/dl_data valid.
REQ-007 dl_addr  in  25  byte address of the 16-bit halfword; bit 0 is ignored.
REQ-008 dl_data  in  16  halfword payload.
REQ-009 dl_wait  out  1  stall to the download source; no dl_wr while high.
REQ-010 wb_cyc, wb_stb  out  1 each  Wishbone cycle/strobe; always equal.
REQ-011 wb_we  out  1  always 1 while wb_cyc is high, 0 otherwise.
REQ-012 wb_sel  out  4  byte lanes.
REQ-013 wb_adr  out  26  word-aligned byte address.
REQ-014 wb_dat  out  32  write data.
REQ-015 wb_ack  in  1  Wishbone acknowledge.
REQ-016 busy  out  1  high from dl_en rise until the final write completes.
REQ-017 done  out  1  one-cycle pulse when the final write completes after dl_en falls.
REQ-018 error  out  1  sticky; set on any timeout, cleared at next dl_en rise or reset.
REQ-019 word_count  out  22  number of Wishbone writes completed (acked) in the current download.

Function
REQ-020 States: IDLE, COLLECT (low halfword held), WRITE (cycle outstanding), FINISH.
REQ-021 IDLE→COLLECT on dl_en rise; word_count and error cleared the same cycle.
REQ-022 dl_wr with dl_addr[1]=0 in COLLECT: latch data into low half, set low_pending, record word address dl_addr[23:2].
REQ-023 dl_wr with dl_addr[1]=1 and low_pending with matching word address: issue write wb_sel=1111, wb_dat={dl_data,low}, go WRITE.
REQ-024 dl_wr with dl_addr[1]=1 without matching low_pending: if low_pending, first flush low as partial write (wb_sel=0011), then write upper alone (wb_sel=1100, wb_dat={dl_data,dl_data}); both in order.
REQ-025 dl_wr with dl_addr[1]=0 while low_pending for another word: flush old low (wb_sel=0011) first, then latch new low.
REQ-026 wb_adr = BASE_ADDR + {word_addr,2'b00}, truncated to 26 bits (wraps modulo 2^26).
REQ-027 Cycle is asserted the cycle after the triggering dl_wr; outputs held stable until wb_ack.
REQ-028 dl_wait high from the cycle after any dl_wr that triggers a write until the cycle after the last resulting wb_ack; low otherwise.
REQ-029 On wb_ack: drop wb_cyc/wb_stb the next cycle, increment word_count, return to COLLECT (or next queued write).
REQ-030 wb_ack outside a cycle is ignored.
REQ-031 No ack within ACK_TIMEOUT cycles of cycle start: drop cycle, set error, word_count not incremented, continue as if acked.
REQ-032 dl_en fall: go FINISH; flush low_pending as 0011 write if present; after last ack (or none pending) pulse done, return IDLE, busy low.
REQ-033 dl_wr while dl_en low is ignored; dl_wr while dl_wait high is a protocol error and is ignored.
REQ-034 dl_en rise during FINISH: completes pending flush first, then restarts per REQ-021.

Reset
REQ-035 reset forces IDLE within one cycle, including mid-cycle: wb_cyc=wb_stb=wb_we=0, wb_sel=0, wb_adr=0, wb_dat=0, dl_wait=0, busy=0, done=0, error=0, word_count=0, low_pending=0.
REQ-036 After reset with dl_en already high, no download starts until a fresh dl_en rise.

Configuration
REQ-037 Macro LOADER_CHECKSUM_EN: defined adds output checksum[31:0], cleared at dl_en rise, adding (wb_dat AND lane mask from wb_sel) mod 2^32 on each acked write; undefined: port and logic absent, other behaviour identical.

Verification
REQ-038 Halfwords 0x1234@0x0, 0xABCD@0x2 -> one write adr 0x400000, sel 1111, dat 0xABCD1234, word_count=1.
REQ-039 Single halfword 0x5555@0x4 then dl_en fall -> write adr 0x400004, sel 0011, then done pulse, busy low.
REQ-040 Upper-only 0x7777@0x6 -> write adr 0x400004, sel 1100, dat 0x77777777; dl_wait high until cycle after ack.
REQ-041 wb_ack withheld 255 cycles -> cycle dropped, error=1, word_count unchanged, next write proceeds.
REQ-042 reset asserted while wb_cyc high -> next cycle all outputs at reset values; later ack ignored.
REQ-043 LOADER_CHECKSUM_EN defined, writes 0xABCD1234 and sel-0011 0x00005555 -> checksum=0xABCD6789.

Source files
------------

// File: rtl/rom_loader_bridge.sv
// rom_loader_bridge: packs a 16-bit download stream into 32-bit Wishbone
// writes at BASE_ADDR. An unpaired halfword becomes a partial-lane write.
// A write that sees no acknowledge is abandoned after ACK_TIMEOUT cycles
// and flagged on the sticky error output.
// Optional build macro LOADER_CHECKSUM_EN adds a running checksum output.
module rom_loader_bridge #(
   parameter logic [25:0] BASE_ADDR   = 26'h0400000,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        dl_en,
   input  logic        dl_wr,
   input  logic [24:0] dl_addr,
   input  logic [15:0] dl_data,
   output logic        dl_wait,
   output logic        wb_cyc,
   output logic        wb_stb,
   output logic        wb_we,
   output logic [3:0]  wb_sel,
   output logic [25:0] wb_adr,
   output logic [31:0] wb_dat,
   input  logic        wb_ack,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [21:0] word_count
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [31:0] checksum
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_FINISH} state_e;

   typedef struct packed {
      logic [3:0]  sel;
      logic [25:0] adr;
      logic [31:0] dat;
   } wb_req_t;

   localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

   function automatic logic [25:0] word_adr(input logic [21:0] word);
      return BASE_ADDR + {2'b00, word, 2'b00};
   endfunction

   state_e           state_q, state_d;
   logic             dl_en_q;
   logic [15:0]      low_q, low_d;
   logic             low_pending_q, low_pending_d;
   logic [21:0]      low_word_q, low_word_d;
   logic             cyc_q, cyc_d;
   wb_req_t          req_q, req_d;
   logic             pend_valid_q, pend_valid_d;
   wb_req_t          pend_q, pend_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic [21:0]      word_count_q, word_count_d;
   logic             restart_q, restart_d;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]      cks_q, cks_d;
`endif

   logic        en_rise, en_fall, ack_hit, tmo_hit;
   logic [21:0] in_word;
   logic        unused_addr_bits;

   assign en_rise          = dl_en & ~dl_en_q;
   assign en_fall          = ~dl_en & dl_en_q;
   assign ack_hit          = cyc_q & wb_ack;
   assign tmo_hit          = cyc_q & ~wb_ack & (tmo_q == TMO_LAST);
   assign in_word          = dl_addr[23:2];
   assign unused_addr_bits = ^{dl_addr[24], dl_addr[0]};

   // Next-state, write sequencing and counters.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_d       = state_q;
      low_d         = low_q;
      low_pending_d = low_pending_q;
      low_word_d    = low_word_q;
      cyc_d         = cyc_q;
      req_d         = req_q;
      pend_valid_d  = pend_valid_q;
      pend_d        = pend_q;
      tmo_d         = tmo_q;
      done_d        = 1'b0;
      error_d       = error_q;
      word_count_d  = word_count_q;
      restart_d     = restart_q;
`ifdef LOADER_CHECKSUM_EN
      cks_d         = cks_q;
`endif

      // Retire the outstanding cycle on ack or on timeout.
      if (ack_hit) begin
         cyc_d        = 1'b0;
         word_count_d = word_count_q + 22'd1;
`ifdef LOADER_CHECKSUM_EN
         cks_d = cks_q + (req_q.dat & {{8{req_q.sel[3]}}, {8{req_q.sel[2]}},
                                       {8{req_q.sel[1]}}, {8{req_q.sel[0]}}});
`endif
      end else if (tmo_hit) begin
         cyc_d   = 1'b0;
         error_d = 1'b1;
      end else if (cyc_q) begin
         tmo_d = tmo_q + TMO_W'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (en_rise) begin
               state_d       = S_COLLECT;
               word_count_d  = '0;
               error_d       = 1'b0;
               low_pending_d = 1'b0;
               restart_d     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
               cks_d         = '0;
`endif
            end
         end

         S_COLLECT: begin
            if (en_fall) begin
               state_d = S_FINISH;
            end else if (dl_wr) begin
               if (!dl_addr[1]) begin
                  // A low halfword for a different word pushes the old one out.
                  if (low_pending_q && (low_word_q != in_word)) begin
                     cyc_d   = 1'b1;
                     tmo_d   = '0;
                     req_d   = '{4'b0011, word_adr(low_word_q), {16'h0000, low_q}};
                     state_d = S_WRITE;
                  end
                  low_d         = dl_data;
                  low_word_d    = in_word;
                  low_pending_d = 1'b1;
               end else begin
                  cyc_d         = 1'b1;
                  tmo_d         = '0;
                  state_d       = S_WRITE;
                  low_pending_d = 1'b0;
                  if (low_pending_q && (low_word_q == in_word)) begin
                     req_d = '{4'b1111, word_adr(in_word), {dl_data, low_q}};
                  end else if (low_pending_q) begin
                     req_d        = '{4'b0011, word_adr(low_word_q), {16'h0000, low_q}};
                     pend_valid_d = 1'b1;
                     pend_d       = '{4'b1100, word_adr(in_word), {dl_data, dl_data}};
                  end else begin
                     req_d = '{4'b1100, word_adr(in_word), {dl_data, dl_data}};
                  end
               end
            end
         end

         S_WRITE: begin
            if (!cyc_q && pend_valid_q) begin
               cyc_d        = 1'b1;
               tmo_d        = '0;
               req_d        = pend_q;
               pend_valid_d = 1'b0;
            end else if ((ack_hit || tmo_hit) && !pend_valid_q) begin
               state_d = S_COLLECT;
            end
            if (en_fall) begin
               state_d = S_FINISH;
            end
         end

         S_FINISH: begin
            if (en_rise) begin
               restart_d = 1'b1;
            end else if (en_fall) begin
               restart_d = 1'b0;
            end
            if (!cyc_q && pend_valid_q) begin
               cyc_d        = 1'b1;
               tmo_d        = '0;
               req_d        = pend_q;
               pend_valid_d = 1'b0;
            end else if (!cyc_q && low_pending_q) begin
               cyc_d         = 1'b1;
               tmo_d         = '0;
               req_d         = '{4'b0011, word_adr(low_word_q), {16'h0000, low_q}};
               low_pending_d = 1'b0;
            end else if (!cyc_q) begin
               done_d    = 1'b1;
               restart_d = 1'b0;
               if ((restart_q || en_rise) && dl_en) begin
                  state_d      = S_COLLECT;
                  word_count_d = '0;
                  error_d      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                  cks_d        = '0;
`endif
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q       <= S_IDLE;
         // NOTE: the edge detector resets high so an already-high dl_en is not
         // mistaken for a fresh rise; a real low-to-high transition is needed.
         dl_en_q       <= 1'b1;
         low_q         <= '0;
         low_pending_q <= 1'b0;
         low_word_q    <= '0;
         cyc_q         <= 1'b0;
         req_q         <= '0;
         pend_valid_q  <= 1'b0;
         pend_q        <= '0;
         tmo_q         <= '0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         word_count_q  <= '0;
         restart_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         cks_q         <= '0;
`endif
      end else begin
         // NOTE: non-blocking so every register updates from pre-edge values.
         state_q       <= state_d;
         dl_en_q       <= dl_en;
         low_q         <= low_d;
         low_pending_q <= low_pending_d;
         low_word_q    <= low_word_d;
         cyc_q         <= cyc_d;
         req_q         <= req_d;
         pend_valid_q  <= pend_valid_d;
         pend_q        <= pend_d;
         tmo_q         <= tmo_d;
         done_q        <= done_d;
         error_q       <= error_d;
         word_count_q  <= word_count_d;
         restart_q     <= restart_d;
`ifdef LOADER_CHECKSUM_EN
         cks_q         <= cks_d;
`endif
      end
   end

   assign wb_cyc     = cyc_q;
   assign wb_stb     = cyc_q;
   assign wb_we      = cyc_q;
   assign wb_sel     = req_q.sel;
   assign wb_adr     = req_q.adr;
   assign wb_dat     = req_q.dat;
   assign dl_wait    = cyc_q | pend_valid_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign error      = error_q;
   assign word_count = word_count_q;
`ifdef LOADER_CHECKSUM_EN
   assign checksum   = cks_q;
`endif

endmodule
